// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: phase sequencer for the I2C master datapath (START, address, write or read data, STOP).
// Optional macro I2C_NACK_ABORT_EN: a slave NACK jumps straight to STOP.
`default_nettype none

module i2c_master_ctrl #(
  parameter int ADDR_BYTES = 3,
  parameter int DATA_BYTES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic rw,
  input  logic scl_i,
  input  logic ack_o_i,
  output logic start_bit,
  output logic stop_bit,
  output logic send_addr,
  output logic read_ack,
  output logic send_data,
  output logic repeated_start,
  output logic read_data,
  output logic send_ack,
  output logic ack_i,
  output logic busy,
  output logic done,
  output logic nack_err
);

  localparam int MAX_BYTES = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int BW = $clog2(MAX_BYTES + 1);
  localparam logic [BW-1:0] ADDR_LAST = BW'(ADDR_BYTES - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BYTES - 1);
  localparam logic [BW-1:0] BYTE_ONE  = BW'(1);

`ifdef I2C_NACK_ABORT_EN
  localparam logic NACK_ABORT = 1'b1;
`else
  localparam logic NACK_ABORT = 1'b0;
`endif

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_START  = 4'd1;
  localparam logic [3:0] S_ADDR   = 4'd2;
  localparam logic [3:0] S_AACK   = 4'd3;
  localparam logic [3:0] S_WDATA  = 4'd4;
  localparam logic [3:0] S_WACK   = 4'd5;
  localparam logic [3:0] S_RSTART = 4'd6;
  localparam logic [3:0] S_RDATA  = 4'd7;
  localparam logic [3:0] S_MACK   = 4'd8;
  localparam logic [3:0] S_STOP   = 4'd9;
  localparam logic [3:0] S_DONE   = 4'd10;

  logic [3:0]    state;
  logic [2:0]    bit_cnt;
  logic [BW-1:0] byte_cnt;
  logic          scl_q;
  logic          rw_q;
  logic          fall;

  // scl_q resets high (bus idle level) so releasing reset never fakes a fall
  assign fall = scl_q & ~scl_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      bit_cnt  <= 3'd0;
      byte_cnt <= '0;
      scl_q    <= 1'b1;
      rw_q     <= 1'b0;
      nack_err <= 1'b0;
      busy     <= 1'b0;
    end else begin
      scl_q <= scl_i;
      case (state)
        S_IDLE: begin
          if (req) begin
            rw_q     <= rw;
            nack_err <= 1'b0;
            busy     <= 1'b1;
            bit_cnt  <= 3'd0;
            byte_cnt <= '0;
            state    <= S_START;
          end
        end
        S_START: state <= S_ADDR;
        S_ADDR, S_WDATA, S_RDATA: begin
          if (fall) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              case (state)
                S_ADDR:  state <= S_AACK;
                S_WDATA: state <= S_WACK;
                default: state <= S_MACK;
              endcase
            end
          end
        end
        S_AACK: begin
          if (fall) begin
            if (ack_o_i) nack_err <= 1'b1;
            if (NACK_ABORT && ack_o_i) begin
              byte_cnt <= '0;
              state    <= S_STOP;
            end else if (byte_cnt == ADDR_LAST) begin
              byte_cnt <= '0;
              state    <= rw_q ? S_RSTART : S_WDATA;
            end else begin
              byte_cnt <= byte_cnt + BYTE_ONE;
              state    <= S_ADDR;
            end
          end
        end
        S_WACK: begin
          if (fall) begin
            if (ack_o_i) nack_err <= 1'b1;
            if ((NACK_ABORT && ack_o_i) || (byte_cnt == DATA_LAST)) begin
              byte_cnt <= '0;
              state    <= S_STOP;
            end else begin
              byte_cnt <= byte_cnt + BYTE_ONE;
              state    <= S_WDATA;
            end
          end
        end
        S_RSTART: if (fall) state <= S_RDATA;
        S_MACK: begin
          if (fall) begin
            if (byte_cnt == DATA_LAST) begin
              byte_cnt <= '0;
              state    <= S_STOP;
            end else begin
              byte_cnt <= byte_cnt + BYTE_ONE;
              state    <= S_RDATA;
            end
          end
        end
        S_STOP: state <= S_DONE;
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign start_bit      = (state == S_START);
  assign send_addr      = (state == S_ADDR);
  assign read_ack       = (state == S_AACK) || (state == S_WACK);
  assign send_data      = (state == S_WDATA);
  assign repeated_start = (state == S_RSTART);
  assign read_data      = (state == S_RDATA);
  assign send_ack       = (state == S_MACK);
  assign stop_bit       = (state == S_STOP);
  assign done           = (state == S_DONE);
  // Master NACKs only the final read byte; outside MACK the line value is a don't-care held at 1
  assign ack_i          = (state == S_MACK) ? (byte_cnt == DATA_LAST) : 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: scoreboard bench; expected phase per SCL fall is queued at request time.
`default_nettype none

module tb_i2c_master_ctrl;

  localparam int ADDR_BYTES = 3;
  localparam int DATA_BYTES = 3;
`ifdef I2C_NACK_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  localparam logic [5:0] P_ADDR  = 6'b100000;
  localparam logic [5:0] P_ACK   = 6'b010000;
  localparam logic [5:0] P_WDATA = 6'b001000;
  localparam logic [5:0] P_RS    = 6'b000100;
  localparam logic [5:0] P_RDATA = 6'b000010;
  localparam logic [5:0] P_MACK  = 6'b000001;

  logic clk = 1'b0;
  logic rst, req, rw, scl_i, ack_o_i;
  logic start_bit, stop_bit, send_addr, read_ack, send_data;
  logic repeated_start, read_data, send_ack, ack_i, busy, done, nack_err;

  i2c_master_ctrl #(.ADDR_BYTES(ADDR_BYTES), .DATA_BYTES(DATA_BYTES)) dut (
    .clk(clk), .rst(rst), .req(req), .rw(rw), .scl_i(scl_i), .ack_o_i(ack_o_i),
    .start_bit(start_bit), .stop_bit(stop_bit), .send_addr(send_addr),
    .read_ack(read_ack), .send_data(send_data), .repeated_start(repeated_start),
    .read_data(read_data), .send_ack(send_ack), .ack_i(ack_i), .busy(busy),
    .done(done), .nack_err(nack_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] ph;
    logic       acki;
    logic       drv;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_start = 0, n_stop = 0, n_done = 0, n_multi = 0, n_idle = 0;
  int s_start, s_stop, s_done, s_idle;

  always @(negedge clk) begin
    n_start += int'(start_bit);
    n_stop  += int'(stop_bit);
    n_done  += int'(done);
    n_idle  += int'(!busy);
    if ($countones({start_bit, stop_bit, send_addr, read_ack, send_data,
                    repeated_start, read_data, send_ack, done}) > 1) n_multi++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic snap();
    s_start = n_start; s_stop = n_stop; s_done = n_done; s_idle = n_idle;
  endtask

  task automatic push(input logic [5:0] ph, input logic acki, input logic drv);
    exp_t e;
    e.ph = ph; e.acki = acki; e.drv = drv;
    exp_q.push_back(e);
  endtask

  // nack_byte: index of the address byte whose ACK slot the slave NACKs (-1 = none)
  task automatic push_txn(input bit r, input int nack_byte);
    for (int b = 0; b < ADDR_BYTES; b++) begin
      for (int i = 0; i < 8; i++) push(P_ADDR, 1'b1, 1'b0);
      push(P_ACK, 1'b1, b == nack_byte);
      if (ABORT && b == nack_byte) return;
    end
    if (!r) begin
      for (int b = 0; b < DATA_BYTES; b++) begin
        for (int i = 0; i < 8; i++) push(P_WDATA, 1'b1, 1'b0);
        push(P_ACK, 1'b1, 1'b0);
      end
    end else begin
      push(P_RS, 1'b1, 1'b0);
      for (int b = 0; b < DATA_BYTES; b++) begin
        for (int i = 0; i < 8; i++) push(P_RDATA, 1'b1, 1'b0);
        push(P_MACK, b == DATA_BYTES - 1, 1'b0);
      end
    end
  endtask

  task automatic fall_n(input int n, input bit hold_req);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("queue_underflow", 1, 0);
        return;
      end
      e = exp_q.pop_front();
      check("phase", {send_addr, read_ack, send_data, repeated_start, read_data, send_ack, ack_i},
            {e.ph, e.acki});
      ack_o_i = e.drv;
      scl_i = 1'b0;
      if (hold_req && i == n - 1) req = 1'b1;
      repeat (4) @(negedge clk);
      scl_i = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic start_req(input bit r);
    snap();
    @(negedge clk);
    req = 1'b1; rw = r;
    @(negedge clk);
    req = 1'b0;
    #1;
    check("start_bit", start_bit, 1);
    check("busy_accept", busy, 1);
    @(negedge clk);
  endtask

  task automatic wait_done(input bit exp_nack, input int exp_starts);
    int k;
    for (k = 0; k < 40 && (n_done - s_done) < 1; k++) @(negedge clk);
    @(negedge clk);
    #1;
    check("done_cnt", n_done - s_done, 1);
    check("stop_cnt", n_stop - s_stop, 1);
    check("start_cnt", n_start - s_start, exp_starts);
    check("nack_err", nack_err, exp_nack);
    check("busy_idle", busy, 0);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic run_txn(input bit r, input int nack_byte, input bit exp_nack);
    start_req(r);
    push_txn(r, nack_byte);
    fall_n(exp_q.size(), 1'b0);
    wait_done(exp_nack, 1);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; rw = 1'b0; scl_i = 1'b1; ack_o_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_strobes", {start_bit, stop_bit, send_addr, read_ack, send_data,
                          repeated_start, read_data, send_ack}, 0);
    check("rst_ack_i", ack_i, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack", nack_err, 0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(1'b0, -1, 1'b0);
    run_txn(1'b1, -1, 1'b0);
    run_txn(1'b0, 1, 1'b1);

    // Reset in the middle of the write data phase, with nack_err still set from above
    start_req(1'b0);
    push_txn(1'b0, -1);
    fall_n(ADDR_BYTES * 9 + 3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_strobes", {start_bit, stop_bit, send_addr, read_ack, send_data,
                              repeated_start, read_data, send_ack}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ack_i", ack_i, 1);
    check("mid_rst_nack", nack_err, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    run_txn(1'b0, -1, 1'b0);

    // Stray req while busy, then req held high from STOP through DONE
    start_req(1'b0);
    push_txn(1'b0, -1);
    fall_n(10, 1'b0);
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    fall_n(exp_q.size(), 1'b1);
    req = 1'b0;
    #1;
    check("hold_done_cnt", n_done - s_done, 1);
    check("hold_start_cnt", n_start - s_start, 2);
    check("hold_idle_gap", (n_idle - s_idle) >= 1, 1);
    check("hold_busy", busy, 1);
    snap();
    push_txn(1'b0, -1);
    fall_n(exp_q.size(), 1'b0);
    wait_done(1'b0, 0);

    check("onehot", n_multi, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
